// File: rtl/sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_if
// Brief    : Request, memory-read and display-result bundle of the sprite
//            fetcher. The slave modport is the fetcher's view; the master
//            modport is the view of whoever issues requests and serves memory.
// Revision : 1.0
// ============================================================================
interface sprite_fetch_if #(
    parameter int ADDR_W = 12
) ();
    // Request side
    logic              start;
    logic [ADDR_W-1:0] i_addr;
    logic [7:0]        vx;
    logic [7:0]        vy;
    logic [3:0]        n;
    // Memory read port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    // Display-stage result
    logic [7:0]        row;
    logic [7:0]        col;
    logic [3:0]        height;
    logic [119:0]      sprite_data;
    logic              draw;
    logic              busy;
    logic              done;

    modport slave (
        input  start, i_addr, vx, vy, n, mem_data,
        output mem_addr, mem_rd, row, col, height, sprite_data, draw, busy, done
    );

    modport master (
        output start, i_addr, vx, vy, n, mem_data,
        input  mem_addr, mem_rd, row, col, height, sprite_data, draw, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch
// Brief    : CHIP-8 DXYN sprite fetcher. Reads N bytes from memory at I,
//            packs them MSbyte-first into a 120-bit word, then strobes draw
//            for DRAW_CYCLES cycles followed by a one-cycle done pulse.
// Revision : 1.0
// ============================================================================
module sprite_fetch #(
    parameter int ADDR_W      = 12,
    parameter int DRAW_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sprite_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    // FETCH: 1-based cycle index since accept. DRAW: 1-based draw cycle index.
    logic [4:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic [7:0]         row_q, row_d;
    logic [7:0]         col_q, col_d;
    logic [3:0]         height_q, height_d;
    logic [119:0]       sprite_q, sprite_d;
    logic               draw_q, draw_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [4:0]         cap_slot;

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            height_q   <= '0;
            sprite_q   <= '0;
            draw_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            row_q      <= row_d;
            col_q      <= col_d;
            height_q   <= height_d;
            sprite_q   <= sprite_d;
            draw_q     <= draw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic for the fetch/draw/done sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        row_d      = row_q;
        col_d      = col_q;
        height_d   = height_q;
        sprite_d   = sprite_q;
        draw_d     = draw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Byte read in cycle c arrives in cycle c+1, so slot = index - 2.
        cap_slot   = cnt_q - 5'd2;

        case (state_q)
            // The done cycle behaves like IDLE so a start held in it is taken.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    row_d    = {3'b000, bus.vy[4:0]};
                    col_d    = {2'b00, bus.vx[5:0]};
                    height_d = bus.n;
                    sprite_d = '0;
                    cnt_d    = 5'd1;
                    if (bus.n == 4'd0) begin
                        // Nothing to read or draw: report completion at once.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = S_FETCH;
                        busy_d     = 1'b1;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.i_addr;
                    end
                end
            end

            S_FETCH: begin
                if (cnt_q >= 5'd2) begin
                    for (int k = 0; k < 15; k++) begin
                        if (cap_slot == 5'(k)) begin
                            sprite_d[(14-k)*8 +: 8] = bus.mem_data;
                        end
                    end
                end
                // Keep issuing back-to-back reads until height bytes are out.
                if (cnt_q < {1'b0, height_q}) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
                if (cnt_q == {1'b0, height_q} + 5'd1) begin
                    state_d = S_DRAW;
                    draw_d  = 1'b1;
                    cnt_d   = 5'd1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_DRAW: begin
                if (cnt_q == 5'(DRAW_CYCLES)) begin
                    state_d = S_DONE;
                    draw_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.height      = height_q;
    assign bus.sprite_data = sprite_q;
    assign bus.draw        = draw_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_fetch
// Brief    : Self-checking bench for sprite_fetch with a behavioural memory
//            and a cycle-numbered reference of the fetch/draw/done timeline.
// Revision : 1.0
// ============================================================================
module tb_sprite_fetch;

    logic clk;
    logic rst_n;
    int   passed;
    int   failed;
    int   total;
    logic [7:0] mem [0:4095];

    sprite_fetch_if #(.ADDR_W(12)) bus ();

    sprite_fetch #(.ADDR_W(12), .DRAW_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after a read; otherwise it drives noise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
        else            bus.mem_data <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference sprite word: byte k of the sprite lands at bit (14-k)*8.
    function automatic logic [119:0] model_sprite(input logic [11:0] a, input int nn);
        logic [119:0] s;
        s = '0;
        for (int k = 0; k < nn; k++)
            s = s | (120'(mem[(int'(a) + k) % 4096]) << ((14 - k) * 8));
        return s;
    endfunction

    task automatic fill(input logic [11:0] a, input int nn);
        for (int k = 0; k < nn; k++) mem[(int'(a) + k) % 4096] = 8'($urandom);
    endtask

    // One request from accept to the done cycle. Returns at the negedge of the
    // done cycle, so the caller may raise start there to test back-to-back.
    task automatic do_req(input logic [11:0] a, input logic [7:0] x, input logic [7:0] y,
                          input int nn, input int poke, input bit pre_started);
        int last;
        logic [119:0] exp_spr;
        if (!pre_started) begin
            @(negedge clk);
            bus.start = 1'b1; bus.i_addr = a; bus.vx = x; bus.vy = y; bus.n = 4'(nn);
        end
        exp_spr = model_sprite(a, nn);
        last = (nn == 0) ? 1 : nn + 4;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            // Later input changes must not affect the request in progress.
            bus.start = (c == poke);
            bus.i_addr = (c == poke) ? 12'h100 : 12'($urandom);
            bus.vx = 8'($urandom); bus.vy = 8'($urandom); bus.n = 4'($urandom);
            chk("mem_rd", 120'(bus.mem_rd), 120'(nn > 0 && c <= nn));
            if (nn > 0 && c <= nn)
                chk("mem_addr", 120'(bus.mem_addr), 120'((int'(a) + c - 1) % 4096));
            chk("draw", 120'(bus.draw), 120'(nn > 0 && (c == nn + 2 || c == nn + 3)));
            chk("done", 120'(bus.done), 120'(c == last));
            if (nn > 0) chk("busy", 120'(bus.busy), 120'(c < last));
            if (c == last || (nn > 0 && c == nn + 2)) begin
                chk("row", 120'(bus.row), 120'(y % 32));
                chk("col", 120'(bus.col), 120'(x % 64));
                chk("height", 120'(bus.height), 120'(nn));
                chk("sprite", bus.sprite_data, exp_spr);
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [11:0] ra;
        int rn;
        passed = 0; failed = 0; total = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        bus.start = 1'b0; bus.i_addr = '0; bus.vx = '0; bus.vy = '0; bus.n = '0;
        bus.mem_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 120'(bus.busy), 120'(0));
        chk("rst_sprite", bus.sprite_data, 120'(0));
        chk("rst_draw", 120'(bus.draw), 120'(0));
        rst_n = 1'b1;

        // Basic fetch with the "0" glyph.
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        do_req(12'h050, 8'd10, 8'd5, 5, 0, 1'b0);
        chk("basic_const", bus.sprite_data, 120'hF0909090F0 << 80);

        // Coordinate wrap, then address wrap.
        fill(12'h200, 1);
        do_req(12'h200, 8'd70, 8'd40, 1, 0, 1'b0);
        chk("wrap_col", 120'(bus.col), 120'(6));
        chk("wrap_row", 120'(bus.row), 120'(8));
        fill(12'hFFF, 2);
        do_req(12'hFFF, 8'd1, 8'd2, 2, 0, 1'b0);
        fill(12'hFFE, 3);
        do_req(12'hFFE, 8'd63, 8'd31, 3, 0, 1'b0);

        // Full height.
        for (int k = 0; k < 15; k++) mem[12'h300 + k] = 8'(k + 1);
        do_req(12'h300, 8'd0, 8'd0, 15, 0, 1'b0);
        chk("full_const", bus.sprite_data, 120'h0102030405060708090A0B0C0D0E0F);

        // Zero height clears the previous sprite.
        do_req(12'h400, 8'd3, 8'd4, 0, 0, 1'b0);

        // Start while busy is ignored; a start in the done cycle is taken.
        fill(12'h500, 5);
        do_req(12'h500, 8'd20, 8'd7, 5, 3, 1'b0);
        fill(12'h600, 4);
        bus.start = 1'b1; bus.i_addr = 12'h600; bus.vx = 8'd33; bus.vy = 8'd17; bus.n = 4'd4;
        do_req(12'h600, 8'd33, 8'd17, 4, 0, 1'b1);

        // Randomised requests.
        for (int it = 0; it < 8; it++) begin
            ra = 12'($urandom);
            rn = $urandom_range(0, 15);
            fill(ra, rn);
            do_req(ra, 8'($urandom), 8'($urandom), rn, 0, 1'b0);
        end

        // Asynchronous reset in cycle 4 of an n=8 fetch.
        fill(12'h700, 8);
        @(negedge clk);
        bus.start = 1'b1; bus.i_addr = 12'h700; bus.vx = 8'd9; bus.vy = 8'd9; bus.n = 4'd8;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_mem_addr", 120'(bus.mem_addr), 120'(0));
        chk("arst_mem_rd", 120'(bus.mem_rd), 120'(0));
        chk("arst_row", 120'(bus.row), 120'(0));
        chk("arst_col", 120'(bus.col), 120'(0));
        chk("arst_height", 120'(bus.height), 120'(0));
        chk("arst_sprite", bus.sprite_data, 120'(0));
        chk("arst_busy", 120'(bus.busy), 120'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 120'({bus.draw, bus.busy, bus.done, bus.mem_rd}), 120'(0));
        end
        fill(12'h800, 6);
        do_req(12'h800, 8'd1, 8'd1, 6, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
